// File: rtl/gcd_sched.sv
// rtl/gcd_sched.sv - round-robin scheduler sharing one 8-bit gcd engine among N requesters
// Optional GCD_SCHED_ZERO_BYPASS_EN: a zero operand is answered directly (a|b) without the engine.
module gcd_sched #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_flat,
  input  logic [N*W-1:0] b_flat,
  output logic [N-1:0]   gnt,
  output logic           rsp_valid,
  output logic [2:0]     rsp_id,
  output logic [W-1:0]   rsp_data,
  input  logic           rsp_ready,
  output logic           busy,
  output logic           eng_start,
  output logic [W-1:0]   eng_a,
  output logic [W-1:0]   eng_b,
  input  logic           eng_done,
  input  logic [W-1:0]   eng_ret
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0] NV = (PW+1)'(N);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] id_q, id_d;
  logic [W-1:0]  op_a_q, op_a_d;
  logic [W-1:0]  op_b_q, op_b_d;
  logic [W-1:0]  res_q, res_d;

  logic          found;
  logic [PW-1:0] sel;
  logic [PW-1:0] cand;
  logic [PW:0]   sum;
  logic [W-1:0]  a_sel, b_sel;
  logic [N-1:0]  gnt_raw;

  // Scan from ptr upward with wrap-around; the first asserted request wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= NV) sum = sum - NV;
      cand = sum[PW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == PW'(i)) begin
        a_sel = a_flat[i*W +: W];
        b_sel = b_flat[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    gnt_raw = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_raw[sel] = 1'b1;
          id_d         = sel;
          op_a_d       = a_sel;
          op_b_d       = b_sel;
`ifdef GCD_SCHED_ZERO_BYPASS_EN
          if (a_sel == '0 || b_sel == '0) begin
            res_d   = a_sel | b_sel;
            state_d = S_RESP;
          end else begin
            state_d = S_START;
          end
`else
          state_d = S_START;
`endif
        end
      end
      S_START: state_d = S_WAIT;
      // eng_done may still be high from the previous operation outside WAIT.
      S_WAIT: begin
        if (eng_done) begin
          res_d   = eng_ret;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          ptr_d   = (id_q == PW'(N-1)) ? '0 : id_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
    end
  end

  // Grant is combinational, so it is masked while reset is held.
  assign gnt       = rst_n ? gnt_raw : '0;
  assign busy      = (state_q != S_IDLE);
  assign eng_start = (state_q == S_START);
  assign eng_a     = op_a_q;
  assign eng_b     = op_b_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = (state_q == S_RESP) ? 3'(id_q) : 3'd0;
  assign rsp_data  = (state_q == S_RESP) ? res_q : '0;

endmodule

// File: tb/tb_gcd_sched.sv
// tb/tb_gcd_sched.sv - self-checking bench for gcd_sched with a behavioural subtractive gcd engine
module tb_gcd_sched;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_flat = '0;
  logic [N*W-1:0] b_flat = '0;
  logic           rsp_ready = 1'b1;
  logic [N-1:0]   gnt;
  logic           rsp_valid;
  logic [2:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           busy;
  logic           eng_start;
  logic [W-1:0]   eng_a, eng_b;
  logic           eng_done = 1'b1;
  logic [W-1:0]   eng_ret = 8'hAA;
  logic [W-1:0]   e_x = '0, e_y = '0;
  logic           e_run = 1'b0;

  gcd_sched #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy), .eng_start(eng_start),
    .eng_a(eng_a), .eng_b(eng_b), .eng_done(eng_done), .eng_ret(eng_ret)
  );

  always #5 clk = ~clk;

  // Engine without reset: done stays high until the next start.
  always @(posedge clk) begin
    if (eng_start) begin
      e_x <= eng_a; e_y <= eng_b; e_run <= 1'b1; eng_done <= 1'b0;
    end else if (e_run) begin
      if (e_x == 0 || e_y == 0 || e_x == e_y) begin
        eng_ret <= (e_x == 0) ? e_y : e_x; eng_done <= 1'b1; e_run <= 1'b0;
      end else if (e_x > e_y) e_x <= e_x - e_y;
      else e_y <= e_y - e_x;
    end
  end

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int start_cnt = 0, start_cyc = 0, grant_cyc = 0, rsp_cyc = 0;
  logic [2:0]   exp_id_q[$];
  logic [W-1:0] exp_dat_q[$];
  int           grant_log[$];
  logic         got_rsp = 1'b0, got_exp_ok = 1'b0;
  logic [2:0]   got_id = '0, got_exp_id = '0;
  logic [W-1:0] got_data = '0, got_exp_data = '0;

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_flat[i*W +: W] = a;
    b_flat[i*W +: W] = b;
    req[i] = 1'b1;
  endtask

  // One cycle: sample at negedge, push expectations on grant, pop on handshake.
  task automatic step();
    logic [N-1:0] g;
    @(negedge clk);
    cyc++;
    g = gnt;
    got_rsp = 1'b0;
    if (eng_start) begin start_cnt++; start_cyc = cyc; end
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        grant_log.push_back(i);
        grant_cyc = cyc;
        exp_id_q.push_back(3'(i));
        exp_dat_q.push_back(gcd_ref(a_flat[i*W +: W], b_flat[i*W +: W]));
      end
    end
    if (rsp_valid && rsp_ready) begin
      got_rsp = 1'b1; got_id = rsp_id; got_data = rsp_data; rsp_cyc = cyc;
      got_exp_ok = (exp_id_q.size() > 0);
      if (got_exp_ok) begin
        got_exp_id = exp_id_q.pop_front();
        got_exp_data = exp_dat_q.pop_front();
      end
    end
    @(posedge clk); #1;
    req = req & ~g;
  endtask

  task automatic wait_rsp(input int maxc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < maxc && !ok; c++) begin
      step();
      if (got_rsp) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_id_q.delete(); exp_dat_q.delete(); grant_log.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_op(0, 8'd4, 8'd6); set_op(3, 8'd9, 8'd3);
    repeat (2) @(negedge clk);
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    n_cmp++; if ({busy, rsp_valid, eng_start} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b want=000", {busy, rsp_valid, eng_start}); end
    n_cmp++; if ({rsp_id, rsp_data, eng_a, eng_b} !== 27'd0) begin n_bad++; $display("FAIL reset_data got=%h want=0", {rsp_id, rsp_data, eng_a, eng_b}); end
    req = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle busy got=%b want=0", busy); end
  endtask

  task automatic test_single();
    bit ok;
    start_cnt = 0;
    set_op(1, 8'd48, 8'd18);
    #1;
    n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL single_gnt got=%b want=0010", gnt); end
    wait_rsp(200, ok);
    n_cmp++; if (!ok || !got_exp_ok) begin n_bad++; $display("FAIL single_rsp got=%0d want=1 (timeout or unexpected)", ok); end
    n_cmp++; if (got_id !== got_exp_id || got_data !== got_exp_data) begin n_bad++; $display("FAIL single_sb got=%0d/%0d want=%0d/%0d", got_id, got_data, got_exp_id, got_exp_data); end
    n_cmp++; if (got_data !== 8'd6) begin n_bad++; $display("FAIL single_data got=%0d want=6", got_data); end
    n_cmp++; if (start_cnt != 1) begin n_bad++; $display("FAIL single_starts got=%0d want=1", start_cnt); end
    n_cmp++; if (start_cyc != grant_cyc + 1) begin n_bad++; $display("FAIL single_start_lat got=%0d want=%0d", start_cyc, grant_cyc + 1); end
    step();
  endtask

  task automatic test_round_robin();
    int nr;
    bit re0;
    int want[4];
    want = '{0, 2, 3, 0};
    do_reset();
    nr = 0; re0 = 1'b0;
    set_op(0, 8'd12, 8'd8); set_op(2, 8'd100, 8'd75); set_op(3, 8'd81, 8'd27);
    for (int c = 0; c < 600 && nr < 4; c++) begin
      step();
      if (!re0 && req[0] == 1'b0) begin set_op(0, 8'd64, 8'd40); re0 = 1'b1; end
      if (got_rsp) begin
        nr++;
        n_cmp++; if (!got_exp_ok || got_id !== got_exp_id || got_data !== got_exp_data) begin n_bad++; $display("FAIL rr_rsp%0d got=%0d/%0d want=%0d/%0d", nr, got_id, got_data, got_exp_id, got_exp_data); end
      end
    end
    n_cmp++; if (nr != 4 || grant_log.size() != 4) begin n_bad++; $display("FAIL rr_count got=%0d/%0d want=4/4", nr, grant_log.size()); end
    for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
      n_cmp++; if (grant_log[k] != want[k]) begin n_bad++; $display("FAIL rr_order%0d got=%0d want=%0d", k, grant_log[k], want[k]); end
    end
    step();
  endtask

  task automatic test_zero();
    bit ok;
    start_cnt = 0;
    set_op(2, 8'd0, 8'd35);
    wait_rsp(200, ok);
    n_cmp++; if (!ok || got_data !== 8'd35 || got_id !== 3'd2) begin n_bad++; $display("FAIL zero_rsp got=%0d/%0d want=2/35", got_id, got_data); end
    n_cmp++; if (!got_exp_ok || got_data !== got_exp_data) begin n_bad++; $display("FAIL zero_sb got=%0d want=%0d", got_data, got_exp_data); end
`ifdef GCD_SCHED_ZERO_BYPASS_EN
    n_cmp++; if (start_cnt != 0) begin n_bad++; $display("FAIL zero_starts got=%0d want=0", start_cnt); end
    n_cmp++; if (rsp_cyc != grant_cyc + 1) begin n_bad++; $display("FAIL zero_lat got=%0d want=%0d", rsp_cyc, grant_cyc + 1); end
`else
    n_cmp++; if (start_cnt != 1) begin n_bad++; $display("FAIL zero_starts got=%0d want=1", start_cnt); end
`endif
    step();
  endtask

  task automatic test_stall();
    bit ok;
    rsp_ready = 1'b0;
    set_op(3, 8'd84, 8'd36);
    for (int c = 0; c < 200 && rsp_valid !== 1'b1; c++) step();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid got=%b want=1", rsp_valid); end
    set_op(0, 8'd9, 8'd6);
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++; if ({rsp_valid, rsp_id, rsp_data, gnt} !== {1'b1, 3'd3, 8'd12, 4'b0000}) begin
        n_bad++; $display("FAIL stall_hold%0d got=%b/%0d/%0d/%b want=1/3/12/0000", c, rsp_valid, rsp_id, rsp_data, gnt);
      end
    end
    rsp_ready = 1'b1;
    wait_rsp(5, ok);
    n_cmp++; if (!ok || !got_exp_ok || got_id !== 3'd3 || got_data !== got_exp_data) begin n_bad++; $display("FAIL stall_rsp got=%0d/%0d want=3/%0d", got_id, got_data, got_exp_data); end
    wait_rsp(200, ok);
    n_cmp++; if (!ok || !got_exp_ok || got_id !== 3'd0 || got_data !== 8'd3) begin n_bad++; $display("FAIL stall_next got=%0d/%0d want=0/3", got_id, got_data); end
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_cnt = 0;
    set_op(1, 8'd200, 8'd150);
    for (int c = 0; c < 20 && start_cnt == 0; c++) step();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_wait busy got=%b want=1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({gnt, busy, rsp_valid, eng_start} !== 7'd0) begin n_bad++; $display("FAIL rmid_flags got=%b want=0", {gnt, busy, rsp_valid, eng_start}); end
    n_cmp++; if ({rsp_id, rsp_data, eng_a, eng_b} !== 27'd0) begin n_bad++; $display("FAIL rmid_data got=%h want=0", {rsp_id, rsp_data, eng_a, eng_b}); end
    exp_id_q.delete(); exp_dat_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) step();
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_idle got=%b%b want=00", busy, rsp_valid); end
    set_op(1, 8'd200, 8'd150);
    wait_rsp(200, ok);
    n_cmp++; if (!ok || !got_exp_ok || got_id !== 3'd1 || got_data !== 8'd50) begin n_bad++; $display("FAIL rmid_rsp got=%0d/%0d want=1/50", got_id, got_data); end
    step();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int prev;
    logic [W-1:0] oa[3], ob[3], od[3];
    oa = '{8'd255, 8'd17, 8'd48}; ob = '{8'd17, 8'd255, 8'd18}; od = '{8'd17, 8'd17, 8'd6};
    start_cnt = 0;
    prev = -1;
    for (int k = 0; k < 3; k++) begin
      set_op(0, oa[k], ob[k]);
      wait_rsp(400, ok);
      n_cmp++; if (!ok || !got_exp_ok || got_id !== 3'd0 || got_data !== od[k] || got_data !== got_exp_data) begin
        n_bad++; $display("FAIL b2b_rsp%0d got=%0d/%0d want=0/%0d", k, got_id, got_data, od[k]);
      end
      if (prev >= 0) begin
        n_cmp++; if (grant_cyc != prev + 1) begin n_bad++; $display("FAIL b2b_regrant%0d got=%0d want=%0d", k, grant_cyc, prev + 1); end
      end
      prev = rsp_cyc;
    end
    n_cmp++; if (start_cnt != 3) begin n_bad++; $display("FAIL b2b_starts got=%0d want=3", start_cnt); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
